pipe_stage_skid: RTL and testbench

//  Parametrised inter-stage pipeline register for the RV32IM core. Replaces the fixed per-stage

---
 rtl/pipe_stage_skid.sv | 115 +++++++++++
 tb/tb_pipe_stage_skid.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Reusable inter-stage pipeline register with a two-entry skid buffer,
// a flush-to-bubble path and a saturating bubble counter.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic accept;
    logic pop;

    assign in_ready   = rst_n & ~stall & (state_q != TWO);
    assign out_valid  = (state_q != EMPTY);
    assign accept     = in_valid & in_ready & ~flush;
    assign pop        = out_valid & out_ready;
    assign out_data   = head_data_q;
    assign out_ctrl   = out_valid ? head_ctrl_q : '0;
    assign occupancy  = state_q;
    assign bubble_cnt = bubble_cnt_q;

    always_comb begin
        state_d      = state_q;
        head_data_d  = head_data_q;
        head_ctrl_d  = head_ctrl_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        bubble_cnt_d = bubble_cnt_q;

        if (!out_valid && bubble_cnt_q != '1) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end

        // Flush discards both entries and the same-cycle input.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end else if (accept) begin
                        state_d     = TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d     = ONE;
                        head_data_d = skid_data_q;
                        head_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            head_data_q  <= '0;
            head_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            head_data_q  <= head_data_d;
            head_ctrl_q  <= head_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: queue model of held entries,
// negedge monitor compares every transfer and status output.
module tb_pipe_stage_skid;

    localparam int DW   = 64;
    localparam int CW   = 12;
    localparam int NW   = 4;
    localparam int CMAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;
    logic [NW-1:0] bubble_cnt;

    pipe_stage_skid #(
        .DATA_W(DW),
        .CTRL_W(CW),
        .CNT_W (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } item_t;

    item_t exp_q[$];
    item_t mon_e;
    int    checks = 0;
    int    failures = 0;
    int    exp_occ = 0;
    int    bub = 0;
    logic  exp_in_ready = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: status each cycle, and pop/compare on every completed transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, exp_in_ready);
            chk("occupancy", occupancy, exp_occ);
            chk("out_valid", out_valid, exp_occ != 0);
            chk("bubble_cnt", bubble_cnt, bub);
            if (!out_valid) chk("ctrl_masked", out_ctrl, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e.d);
                    chk("out_ctrl", out_ctrl, mon_e.c);
                end
            end
        end
    end

    // Drive one cycle of inputs and advance the model across the edge.
    task automatic step(input logic iv, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic st,
                        input logic fl, input logic ordy);
        logic  acc;
        item_t it;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
        exp_in_ready = !st && (exp_occ < 2);
        acc  = iv && exp_in_ready && !fl;
        it.d = d;
        it.c = c;
        @(posedge clk);
        #1;
        if (exp_occ == 0 && bub < CMAX) bub++;
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back(it);
        exp_occ = exp_q.size();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_bubble", bubble_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        exp_q.delete();
        exp_occ = 0;
        bub = 0;
        exp_in_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // first entry straight after reset
        step(1'b1, 64'hA5, 12'h3, 1'b0, 1'b0, 1'b1);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 64'hA5);
        chk("t1_occ", occupancy, 1);
        chk("t1_bub", bubble_cnt, 1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // fill both entries, third is refused, then drain in order
        step(1'b1, 64'h11, 12'h1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h22, 12'h2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h33, 12'h3, 1'b0, 1'b0, 1'b0);
        chk("t2_occ", occupancy, 2);
        chk("t2_in_ready", in_ready, 0);
        step(1'b1, 64'h33, 12'h3, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h33, 12'h3, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("t2_drained", occupancy, 0);

        // flush with a full stage and a live input
        step(1'b1, 64'h61, 12'h7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h62, 12'h8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h44, 12'hF, 1'b0, 1'b1, 1'b0);
        chk("t3_occ", occupancy, 0);
        chk("t3_valid", out_valid, 0);
        chk("t3_ctrl", out_ctrl, 0);
        repeat (2) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // stall blocks acceptance but the head still drains
        step(1'b1, 64'h55, 12'h5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h56, 12'h6, 1'b1, 1'b0, 1'b1);
        chk("t4_occ", occupancy, 0);
        repeat (2) step(1'b1, 64'h56, 12'h6, 1'b1, 1'b0, 1'b1);
        step(1'b1, 64'h56, 12'h6, 1'b0, 1'b0, 1'b1);
        chk("t4_accept", occupancy, 1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // bubble counter saturation, then async reset while full
        do_reset();
        repeat (20) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("t5_sat", bubble_cnt, CMAX);
        step(1'b1, 64'h71, 12'h1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h72, 12'h2, 1'b0, 1'b0, 1'b0);
        chk("t5_full", occupancy, 2);
        #2;
        do_reset();

        // randomized traffic with stalls and flushes
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, {$urandom, $urandom}, CW'($urandom),
                 ($urandom % 8) == 0, ($urandom % 16) == 0,
                 ($urandom % 3) != 0);
        end
        repeat (4) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
